pwm_multi: RTL

Parametrised multi-channel PWM generator for the motor/servo drive path. It generalises the single-channel 8-bit switch-driven PWM. Features:
- one shared period counter with programmable clock prescaler and programmable period;
- edge-aligned or center-aligned counting;
- per-channel duty registers written over a simple write port, with double-buffered (glitch-free) update at period boundaries.

Sits between the control/register logic and the output pins.

---
 rtl/pwm_multi.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with shared prescaled counter
//
// Purpose:
//   CHANNELS PWM outputs driven from one shared period counter. The counter
//   advances once every prescale+1 clocks and runs either edge-aligned
//   (0..P, wrap) or center-aligned (0..P..1, back to 0). Each channel has a
//   pending duty register (written any time) and an active duty register
//   (loaded only at period boundaries) so duty changes never cause runt
//   pulses. The active period and counting mode are loaded at the same time.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           run enable; low holds the counter and forces outputs low
//   center       0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   prescale     counter advances once every prescale+1 clocks
//   period       top count value P (taken at boundary)
//   duty_wr      one-cycle write strobe for a pending duty register
//   duty_ch      channel index of the write (out-of-range writes dropped)
//   duty_in      duty value D of the write
//   pwm_out      registered PWM outputs, high while counter < active duty
//   period_tick  registered one-cycle pulse at each period boundary

module pwm_multi #(
    parameter  int CHANNELS   = 4,
    parameter  int WIDTH      = 8,
    parameter  int PRESCALE_W = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  center,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic                  duty_wr,
    input  logic [CH_W-1:0]       duty_ch,
    input  logic [WIDTH-1:0]      duty_in,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_tick
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_pre;
    logic [WIDTH-1:0]      r_cnt;
    logic                  r_dir_down;
    logic [WIDTH-1:0]      r_period_a;
    logic                  r_mode_a;
    logic [WIDTH-1:0]      r_pending [CHANNELS];
    logic [WIDTH-1:0]      r_active  [CHANNELS];
    logic [CHANNELS-1:0]   r_pwm;
    logic                  r_tick;

    logic                  w_tick;
    logic                  w_center_run;
    logic [WIDTH-1:0]      w_cnt_next;
    logic                  w_dir_next;
    logic                  w_boundary;
    logic                  w_wr_ok;
    logic [CHANNELS-1:0]   w_cmp;

    // ------------------------------------------------------------------
    // Prescaler tick: one counter step every prescale+1 enabled clocks
    // ------------------------------------------------------------------
    assign w_tick = en && (r_pre == prescale);

    // Center counting degenerates to edge counting when the top is 0,
    // otherwise the down leg would underflow.
    assign w_center_run = r_mode_a && (r_period_a != '0);

    // ------------------------------------------------------------------
    // Next counter value on a tick
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_down;
        if (!w_center_run) begin
            w_dir_next = 1'b0;
            if (r_cnt == r_period_a) begin
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else if (!r_dir_down) begin
            if (r_cnt == r_period_a) begin
                // Turn around at the top. With P=1 the down leg is empty,
                // so the step lands straight on 0 and stays counting up.
                w_cnt_next = r_cnt - 1'b1;
                w_dir_next = (r_period_a != WIDTH'(1));
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else begin
            w_cnt_next = r_cnt - 1'b1;
            w_dir_next = (r_cnt != WIDTH'(1));
        end
    end

    // A boundary is any tick whose step lands the counter on 0.
    assign w_boundary = w_tick && (w_cnt_next == '0);

    // ------------------------------------------------------------------
    // Prescaler, counter and direction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre      <= '0;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
        end else if (!en) begin
            r_pre      <= '0;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
        end else begin
            if (r_pre == prescale) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            if (w_tick) begin
                r_cnt      <= w_cnt_next;
                r_dir_down <= w_dir_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending / active registers
    // ------------------------------------------------------------------
    assign w_wr_ok = duty_wr && (int'(duty_ch) < CHANNELS);

    // Active copies are refreshed every idle cycle so that enabling starts
    // a fresh period with the newest values. A write on the same edge as a
    // boundary lands in pending only; active picks up the old pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_a <= '0;
            r_mode_a   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            if (!en || w_boundary) begin
                r_period_a <= period;
                r_mode_a   <= center;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_active[i] <= r_pending[i];
                end
            end
            if (w_wr_ok) begin
                r_pending[duty_ch] <= duty_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare and output registers
    // ------------------------------------------------------------------
    always_comb begin
        w_cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cmp[i] = (r_cnt < r_active[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pwm  <= en ? w_cmp : '0;
            r_tick <= w_boundary;
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_tick;

endmodule
